// File: rtl/triangle_culler_if.sv
// triangle_culler_if: fetch-side handshake, vertex/viewport inputs and verdict outputs of the culler
interface triangle_culler_if #(
    parameter int COORD_WIDTH = 32,
    parameter int CNT_WIDTH = 16
);
    logic en;
    logic startCull;
    logic [2*COORD_WIDTH-1:0] Pa, Pb, Pc;
    logic [1:0] cullMode;
    logic [COORD_WIDTH-1:0] vpXmin, vpXmax, vpYmin, vpYmax;
    logic busy, done, cull, startRaster;
    logic [2*COORD_WIDTH+2:0] area;
    logic [CNT_WIDTH-1:0] triInCount, triCulledCount;

    modport master (
        output en, startCull, Pa, Pb, Pc, cullMode, vpXmin, vpXmax, vpYmin, vpYmax,
        input busy, done, cull, startRaster, area, triInCount, triCulledCount
    );
    modport slave (
        input en, startCull, Pa, Pb, Pc, cullMode, vpXmin, vpXmax, vpYmin, vpYmax,
        output busy, done, cull, startRaster, area, triInCount, triCulledCount
    );
endinterface

// File: rtl/triangle_culler.sv
// triangle_culler: signed-area facing test and bounding-box viewport rejection,
// one shared multiplier over a SUB/MUL0/MUL1/DECIDE sequence.
module triangle_culler #(
    parameter int COORD_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input logic clk,
    input logic resetn,
    triangle_culler_if.slave bus
);
    localparam int W = COORD_WIDTH;

    typedef enum logic [2:0] {IDLE, SUB, MUL0, MUL1, DECIDE} state_t;

    state_t state;
    logic [2*W-1:0] pa, pb, pc;
    logic [1:0] mode;
    logic signed [W-1:0] vx0, vx1, vy0, vy1;
    logic signed [W-1:0] xa, ya, xb, yb, xc, yc, mnx, mxx, mny, mxy;
    logic signed [W:0] dxb, dyb, dxc, dyc, ma, mb;
    logic signed [2*W+1:0] p1, p2, prod;
    logic signed [2*W+2:0] diff;
    logic oov, zero, cull_n;

    function automatic logic signed [W-1:0] smin(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        return a < b ? a : b;
    endfunction

    function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        return a > b ? a : b;
    endfunction

    assign {xa, ya} = pa;
    assign {xb, yb} = pb;
    assign {xc, yc} = pc;
    assign mnx = smin(smin(xa, xb), xc);
    assign mxx = smax(smax(xa, xb), xc);
    assign mny = smin(smin(ya, yb), yc);
    assign mxy = smax(smax(ya, yb), yc);

    // Operand mux in front of the single multiplier: MUL0 forms dxb*dyc, MUL1 dxc*dyb
    assign ma = state == MUL0 ? dxb : dxc;
    assign mb = state == MUL0 ? dyc : dyb;
    assign prod = (2*W+2)'(ma) * (2*W+2)'(mb);
    assign diff = (2*W+3)'(p1) - (2*W+3)'(p2);
    assign zero = diff == '0;
    assign cull_n = oov | zero | (mode[0] & diff[2*W+2]) | (mode[1] & ~diff[2*W+2] & ~zero);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            pa <= '0;
            pb <= '0;
            pc <= '0;
            mode <= '0;
            vx0 <= '0;
            vx1 <= '0;
            vy0 <= '0;
            vy1 <= '0;
            dxb <= '0;
            dyb <= '0;
            dxc <= '0;
            dyc <= '0;
            p1 <= '0;
            p2 <= '0;
            oov <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.cull <= 1'b0;
            bus.startRaster <= 1'b0;
            bus.area <= '0;
            bus.triInCount <= '0;
            bus.triCulledCount <= '0;
        end else if (!bus.en) begin
            bus.done <= 1'b0;
            bus.startRaster <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    bus.startRaster <= 1'b0;
                    if (bus.startCull) begin
                        pa <= bus.Pa;
                        pb <= bus.Pb;
                        pc <= bus.Pc;
                        mode <= bus.cullMode;
                        vx0 <= bus.vpXmin;
                        vx1 <= bus.vpXmax;
                        vy0 <= bus.vpYmin;
                        vy1 <= bus.vpYmax;
                        bus.busy <= 1'b1;
                        bus.triInCount <= bus.triInCount + CNT_WIDTH'(1);
                        state <= SUB;
                    end
                end
                SUB: begin
                    dxb <= {xb[W-1], xb} - {xa[W-1], xa};
                    dyb <= {yb[W-1], yb} - {ya[W-1], ya};
                    dxc <= {xc[W-1], xc} - {xa[W-1], xa};
                    dyc <= {yc[W-1], yc} - {ya[W-1], ya};
                    oov <= (mxx < vx0) | (mnx > vx1) | (mxy < vy0) | (mny > vy1);
                    state <= MUL0;
                end
                MUL0: begin
                    p1 <= prod;
                    state <= MUL1;
                end
                MUL1: begin
                    p2 <= prod;
                    state <= DECIDE;
                end
                DECIDE: begin
                    bus.area <= diff;
                    bus.cull <= cull_n;
                    bus.done <= 1'b1;
                    bus.startRaster <= ~cull_n;
                    bus.busy <= 1'b0;
                    if (cull_n) bus.triCulledCount <= bus.triCulledCount + CNT_WIDTH'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
